// File: rtl/fpu_op_sequencer.sv
// Sequences ESC instructions from CPU microcode into the FPU interface. It assembles
// 16-bit load words into the 80-bit operand, splits results into store words and runs a watchdog.
module fpu_op_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [7:0]  op_opcode,
    input  logic [7:0]  op_modrm,
    input  logic        op_is_load,
    input  logic        op_is_store,
    input  logic [1:0]  op_size,
    input  logic        op_is_integer,
    input  logic        op_is_bcd,
    input  logic        wr_word_valid,
    input  logic [15:0] wr_word,
    output logic        wr_word_ready,
    output logic        rd_word_valid,
    output logic [15:0] rd_word,
    input  logic        rd_word_ready,
    input  logic        fwait,
    output logic        fwait_stall,
    output logic        done,
    output logic        timeout_err,
    output logic        fpu_instr_valid,
    output logic [7:0]  fpu_opcode,
    output logic [7:0]  fpu_modrm,
    output logic        fpu_has_memory_op,
    output logic [1:0]  fpu_operand_size,
    output logic        fpu_is_integer,
    output logic        fpu_is_bcd,
    input  logic        fpu_instr_ack,
    output logic        fpu_data_write,
    output logic [79:0] fpu_data_in,
    output logic        fpu_data_read,
    input  logic [79:0] fpu_data_out,
    input  logic        fpu_data_ready,
    input  logic        fpu_busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ISSUE, ST_LOAD_COLLECT, ST_LOAD_PUSH,
        ST_EXEC_WAIT, ST_STORE_WAIT, ST_STORE_SEND
    } state_t;

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_word_cnt;
    logic [79:0]   r_operand;
    logic [79:0]   r_result;
    logic [7:0]    r_opcode;
    logic [7:0]    r_modrm;
    logic          r_is_load;
    logic          r_is_store;
    logic [1:0]    r_size;
    logic          r_is_integer;
    logic          r_is_bcd;
    logic          r_instr_valid;
    logic          r_wr_word_ready;
    logic          r_rd_word_valid;
    logic          r_data_write;
    logic          r_data_read;
    logic          r_done;
    logic          r_timeout_err;

    logic [2:0]    w_n_words;
    logic          w_last_word;
    logic          w_timed;
    logic          w_expired;
    logic [15:0]   w_rd_word;

    always_comb begin
        w_n_words = 3'd1;
        case (r_size)
            2'd0: w_n_words = 3'd1;
            2'd1: w_n_words = 3'd2;
            2'd2: w_n_words = 3'd4;
            2'd3: w_n_words = 3'd5;
            default: w_n_words = 3'd1;
        endcase
    end

    assign w_last_word = (r_word_cnt == w_n_words - 3'd1);
    assign w_timed     = (r_state == ST_ISSUE) || (r_state == ST_EXEC_WAIT) ||
                         (r_state == ST_STORE_WAIT);
    assign w_expired   = w_timed && (r_timer == TIMER_LAST);

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < 5; i++) begin
            if (r_word_cnt == 3'(i)) w_rd_word = r_result[16*i +: 16];
        end
    end

    // NOTE: op_ready is gated by reset_n so that every output reads 0 while reset is held,
    // even though the state register already sits in IDLE.
    assign op_ready          = (r_state == ST_IDLE) && reset_n;
    assign fwait_stall       = fwait && (r_state != ST_IDLE);
    assign rd_word           = w_rd_word;
    assign wr_word_ready     = r_wr_word_ready;
    assign rd_word_valid     = r_rd_word_valid;
    assign done              = r_done;
    assign timeout_err       = r_timeout_err;
    assign fpu_instr_valid   = r_instr_valid;
    assign fpu_opcode        = r_opcode;
    assign fpu_modrm         = r_modrm;
    assign fpu_has_memory_op = r_is_load || r_is_store;
    assign fpu_operand_size  = r_size;
    assign fpu_is_integer    = r_is_integer;
    assign fpu_is_bcd        = r_is_bcd;
    assign fpu_data_write    = r_data_write;
    assign fpu_data_in       = r_operand;
    assign fpu_data_read     = r_data_read;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_timer         <= '0;
            r_word_cnt      <= '0;
            r_operand       <= '0;
            r_result        <= '0;
            r_opcode        <= '0;
            r_modrm         <= '0;
            r_is_load       <= 1'b0;
            r_is_store      <= 1'b0;
            r_size          <= '0;
            r_is_integer    <= 1'b0;
            r_is_bcd        <= 1'b0;
            r_instr_valid   <= 1'b0;
            r_wr_word_ready <= 1'b0;
            r_rd_word_valid <= 1'b0;
            r_data_write    <= 1'b0;
            r_data_read     <= 1'b0;
            r_done          <= 1'b0;
            r_timeout_err   <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_data_write <= 1'b0;
            r_data_read  <= 1'b0;
            if (w_timed) r_timer <= r_timer + 1'b1;

            if (w_expired) begin
                r_state       <= ST_IDLE;
                r_timer       <= '0;
                r_instr_valid <= 1'b0;
                r_timeout_err <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (op_valid) begin
                            r_opcode      <= op_opcode;
                            r_modrm       <= op_modrm;
                            r_is_load     <= op_is_load;
                            r_is_store    <= op_is_store && !op_is_load;
                            r_size        <= op_size;
                            r_is_integer  <= op_is_integer;
                            r_is_bcd      <= op_is_bcd;
                            r_word_cnt    <= '0;
                            r_operand     <= '0;
                            r_timeout_err <= 1'b0;
                            r_instr_valid <= 1'b1;
                            r_timer       <= '0;
                            r_state       <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        if (fpu_instr_ack) begin
                            r_instr_valid <= 1'b0;
                            r_timer       <= '0;
                            if (r_is_load) begin
                                r_wr_word_ready <= 1'b1;
                                r_state         <= ST_LOAD_COLLECT;
                            end else if (r_is_store) begin
                                r_state <= ST_STORE_WAIT;
                            end else begin
                                r_state <= ST_EXEC_WAIT;
                            end
                        end
                    end
                    ST_LOAD_COLLECT: begin
                        if (wr_word_valid) begin
                            for (int i = 0; i < 5; i++) begin
                                if (r_word_cnt == 3'(i)) r_operand[16*i +: 16] <= wr_word;
                            end
                            r_word_cnt <= r_word_cnt + 3'd1;
                            if (w_last_word) begin
                                r_wr_word_ready <= 1'b0;
                                r_data_write    <= 1'b1;
                                r_timer         <= '0;
                                r_state         <= ST_LOAD_PUSH;
                            end
                        end
                    end
                    ST_LOAD_PUSH: begin
                        r_timer <= '0;
                        r_state <= ST_EXEC_WAIT;
                    end
                    ST_EXEC_WAIT: begin
                        // A zero timer marks the first cycle, when fpu_busy may not yet reflect this op.
                        if (r_timer != '0 && !fpu_busy) begin
                            r_done  <= 1'b1;
                            r_timer <= '0;
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_STORE_WAIT: begin
                        if (fpu_data_ready) begin
                            r_result        <= fpu_data_out;
                            r_data_read     <= 1'b1;
                            r_word_cnt      <= '0;
                            r_rd_word_valid <= 1'b1;
                            r_timer         <= '0;
                            r_state         <= ST_STORE_SEND;
                        end
                    end
                    ST_STORE_SEND: begin
                        if (rd_word_ready) begin
                            r_word_cnt <= r_word_cnt + 3'd1;
                            if (w_last_word) begin
                                r_rd_word_valid <= 1'b0;
                                r_done          <= 1'b1;
                                r_timer         <= '0;
                                r_state         <= ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        r_timer <= '0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed bench for fpu_op_sequencer: register op, loads, store, watchdog, fwait and mid-op reset.
module tb_fpu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        op_valid, op_ready;
    logic [7:0]  op_opcode, op_modrm;
    logic        op_is_load, op_is_store;
    logic [1:0]  op_size;
    logic        op_is_integer, op_is_bcd;
    logic        wr_word_valid;
    logic [15:0] wr_word;
    logic        wr_word_ready;
    logic        rd_word_valid;
    logic [15:0] rd_word;
    logic        rd_word_ready;
    logic        fwait, fwait_stall;
    logic        done, timeout_err;
    logic        fpu_instr_valid;
    logic [7:0]  fpu_opcode, fpu_modrm;
    logic        fpu_has_memory_op;
    logic [1:0]  fpu_operand_size;
    logic        fpu_is_integer, fpu_is_bcd;
    logic        fpu_instr_ack;
    logic        fpu_data_write;
    logic [79:0] fpu_data_in;
    logic        fpu_data_read;
    logic [79:0] fpu_data_out;
    logic        fpu_data_ready;
    logic        fpu_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse counters sampled on the falling edge.
    int  n_done = 0, n_write = 0, n_read = 0, n_iv_burst = 0;
    bit  prev_iv = 1'b0;

    always #5 clk = ~clk;

    fpu_op_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_opcode(op_opcode), .op_modrm(op_modrm),
        .op_is_load(op_is_load), .op_is_store(op_is_store), .op_size(op_size),
        .op_is_integer(op_is_integer), .op_is_bcd(op_is_bcd),
        .wr_word_valid(wr_word_valid), .wr_word(wr_word), .wr_word_ready(wr_word_ready),
        .rd_word_valid(rd_word_valid), .rd_word(rd_word), .rd_word_ready(rd_word_ready),
        .fwait(fwait), .fwait_stall(fwait_stall), .done(done), .timeout_err(timeout_err),
        .fpu_instr_valid(fpu_instr_valid), .fpu_opcode(fpu_opcode), .fpu_modrm(fpu_modrm),
        .fpu_has_memory_op(fpu_has_memory_op), .fpu_operand_size(fpu_operand_size),
        .fpu_is_integer(fpu_is_integer), .fpu_is_bcd(fpu_is_bcd),
        .fpu_instr_ack(fpu_instr_ack), .fpu_data_write(fpu_data_write),
        .fpu_data_in(fpu_data_in), .fpu_data_read(fpu_data_read),
        .fpu_data_out(fpu_data_out), .fpu_data_ready(fpu_data_ready), .fpu_busy(fpu_busy)
    );

    always @(negedge clk) begin
        if (done === 1'b1) n_done++;
        if (fpu_data_write === 1'b1) n_write++;
        if (fpu_data_read === 1'b1) n_read++;
        if (fpu_instr_valid === 1'b1 && !prev_iv) n_iv_burst++;
        prev_iv = (fpu_instr_valid === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] opc, input logic [7:0] mrm, input logic ld,
                            input logic st, input logic [1:0] sz, input logic intg);
        op_opcode = opc; op_modrm = mrm; op_is_load = ld; op_is_store = st;
        op_size = sz; op_is_integer = intg; op_is_bcd = 1'b0;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        op_valid = 0; op_opcode = 0; op_modrm = 0; op_is_load = 0; op_is_store = 0;
        op_size = 0; op_is_integer = 0; op_is_bcd = 0; wr_word_valid = 0; wr_word = 0;
        rd_word_ready = 0; fwait = 1; fpu_instr_ack = 0; fpu_data_out = 0;
        fpu_data_ready = 0; fpu_busy = 0;
        #23;
        n_checks++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL rst_op_ready: got %b expected 0", op_ready); end
        n_checks++; if (fwait_stall !== 1'b0) begin n_fail++; $display("FAIL rst_fwait_stall: got %b expected 0", fwait_stall); end
        n_checks++; if ({done, timeout_err, fpu_instr_valid, wr_word_ready, rd_word_valid, fpu_data_write, fpu_data_read} !== 7'b0) begin
            n_fail++; $display("FAIL rst_flags: got %b expected 0000000", {done, timeout_err, fpu_instr_valid, wr_word_ready, rd_word_valid, fpu_data_write, fpu_data_read}); end
        n_checks++; if (fpu_data_in !== 80'h0 || rd_word !== 16'h0) begin n_fail++; $display("FAIL rst_data: got %h/%h expected 0/0", fpu_data_in, rd_word); end
        fwait = 0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b expected 1", op_ready); end
    endtask

    task automatic test_register_op();
        int d0 = n_done, b0 = n_iv_burst;
        bit seen;
        fpu_busy = 1'b1;
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL reg_ready_before: got %b expected 1", op_ready); end
        start_op(8'hD8, 8'hC0, 0, 0, 2'd0, 0);
        n_checks++; if (fpu_instr_valid !== 1'b1 || op_ready !== 1'b0) begin n_fail++; $display("FAIL reg_issue: got valid=%b ready=%b expected 1/0", fpu_instr_valid, op_ready); end
        n_checks++; if (fpu_opcode !== 8'hD8 || fpu_modrm !== 8'hC0 || fpu_has_memory_op !== 1'b0) begin
            n_fail++; $display("FAIL reg_desc: got %h/%h/%b expected d8/c0/0", fpu_opcode, fpu_modrm, fpu_has_memory_op); end
        tick();
        fpu_instr_ack = 1'b1;
        tick();
        fpu_instr_ack = 1'b0;
        n_checks++; if (fpu_instr_valid !== 1'b0) begin n_fail++; $display("FAIL reg_valid_drop: got %b expected 0", fpu_instr_valid); end
        tick(); tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reg_done_early: got %b expected 0", done); end
        fpu_busy = 1'b0;
        wait_done(20, seen);
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL reg_done_seen: got %b expected 1", seen); end
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL reg_ready_after: got %b expected 1", op_ready); end
        tick(); tick();
        n_checks++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL reg_done_count: got %0d expected 1", n_done - d0); end
        n_checks++; if (n_iv_burst - b0 !== 1) begin n_fail++; $display("FAIL reg_valid_bursts: got %0d expected 1", n_iv_burst - b0); end
    endtask

    task automatic test_load_single();
        int w0 = n_write;
        bit seen;
        start_op(8'hD8, 8'h06, 1, 0, 2'd1, 0);
        fpu_instr_ack = 1'b1;
        tick();
        fpu_instr_ack = 1'b0;
        n_checks++; if (wr_word_ready !== 1'b1 || fpu_has_memory_op !== 1'b1 || fpu_operand_size !== 2'd1) begin
            n_fail++; $display("FAIL ld1_collect: got rdy=%b mem=%b sz=%0d expected 1/1/1", wr_word_ready, fpu_has_memory_op, fpu_operand_size); end
        wr_word_valid = 1'b1; wr_word = 16'h0000;
        tick();
        wr_word = 16'h3F80;
        tick();
        wr_word_valid = 1'b0;
        n_checks++; if (fpu_data_write !== 1'b1 || fpu_data_in !== 80'h3F800000) begin
            n_fail++; $display("FAIL ld1_push: got wr=%b data=%h expected 1/3f800000", fpu_data_write, fpu_data_in); end
        wait_done(20, seen);
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL ld1_done: got %b expected 1", seen); end
        tick();
        n_checks++; if (n_write - w0 !== 1) begin n_fail++; $display("FAIL ld1_write_count: got %0d expected 1", n_write - w0); end
    endtask

    task automatic test_load_80();
        int w0 = n_write;
        bit seen;
        start_op(8'hDB, 8'h2E, 1, 0, 2'd3, 1);
        fpu_instr_ack = 1'b1;
        tick();
        fpu_instr_ack = 1'b0;
        n_checks++; if (fpu_is_integer !== 1'b1) begin n_fail++; $display("FAIL ld5_integer: got %b expected 1", fpu_is_integer); end
        for (int i = 1; i <= 5; i++) begin
            if (i == 3) begin
                wr_word_valid = 1'b0;
                tick(); tick(); tick();
                n_checks++; if (wr_word_ready !== 1'b1 || fpu_data_write !== 1'b0) begin
                    n_fail++; $display("FAIL ld5_stall: got rdy=%b wr=%b expected 1/0", wr_word_ready, fpu_data_write); end
            end
            wr_word_valid = 1'b1; wr_word = 16'(i);
            tick();
        end
        wr_word_valid = 1'b0;
        n_checks++; if (fpu_data_write !== 1'b1 || fpu_data_in !== 80'h00050004000300020001) begin
            n_fail++; $display("FAIL ld5_push: got wr=%b data=%h expected 1/00050004000300020001", fpu_data_write, fpu_data_in); end
        wait_done(20, seen);
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL ld5_done: got %b expected 1", seen); end
        tick();
        n_checks++; if (n_write - w0 !== 1) begin n_fail++; $display("FAIL ld5_write_count: got %0d expected 1", n_write - w0); end
    endtask

    task automatic test_store();
        logic [15:0] exp_words [5];
        int r0 = n_read;
        exp_words = '{16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h3FFF};
        start_op(8'hD9, 8'h16, 0, 1, 2'd3, 0);
        fpu_instr_ack = 1'b1;
        tick();
        fpu_instr_ack = 1'b0;
        tick();
        n_checks++; if (rd_word_valid !== 1'b0 || fpu_data_read !== 1'b0) begin
            n_fail++; $display("FAIL st_wait: got valid=%b read=%b expected 0/0", rd_word_valid, fpu_data_read); end
        fpu_data_out = 80'h3FFF8000000000000000; fpu_data_ready = 1'b1;
        tick();
        fpu_data_ready = 1'b0; fpu_data_out = 80'h0;
        n_checks++; if (fpu_data_read !== 1'b1) begin n_fail++; $display("FAIL st_read_pulse: got %b expected 1", fpu_data_read); end
        tick(); tick();
        n_checks++; if (rd_word_valid !== 1'b1 || rd_word !== 16'h0000 || fpu_data_read !== 1'b0) begin
            n_fail++; $display("FAIL st_hold: got valid=%b word=%h read=%b expected 1/0000/0", rd_word_valid, rd_word, fpu_data_read); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (rd_word_valid !== 1'b1 || rd_word !== exp_words[i]) begin
                n_fail++; $display("FAIL st_word%0d: got valid=%b word=%h expected 1/%h", i, rd_word_valid, rd_word, exp_words[i]); end
            rd_word_ready = 1'b1;
            tick();
        end
        rd_word_ready = 1'b0;
        n_checks++; if (done !== 1'b1 || rd_word_valid !== 1'b0 || op_ready !== 1'b1) begin
            n_fail++; $display("FAIL st_end: got done=%b valid=%b ready=%b expected 1/0/1", done, rd_word_valid, op_ready); end
        tick();
        n_checks++; if (n_read - r0 !== 1) begin n_fail++; $display("FAIL st_read_count: got %0d expected 1", n_read - r0); end
    endtask

    task automatic test_timeout();
        int d0 = n_done;
        start_op(8'hD8, 8'hC0, 0, 0, 2'd0, 0);
        for (int i = 0; i < 15; i++) tick();
        n_checks++; if (fpu_instr_valid !== 1'b1 || timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL to_before: got valid=%b err=%b expected 1/0", fpu_instr_valid, timeout_err); end
        tick();
        n_checks++; if (op_ready !== 1'b1 || timeout_err !== 1'b1 || fpu_instr_valid !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL to_expire: got ready=%b err=%b valid=%b done=%b expected 1/1/0/0", op_ready, timeout_err, fpu_instr_valid, done); end
        tick();
        n_checks++; if (n_done - d0 !== 0) begin n_fail++; $display("FAIL to_no_done: got %0d expected 0", n_done - d0); end
    endtask

    task automatic test_fwait();
        bit seen;
        fpu_busy = 1'b1;
        start_op(8'hD9, 8'hE8, 0, 0, 2'd0, 0);
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL fw_err_clear: got %b expected 0", timeout_err); end
        fpu_instr_ack = 1'b1;
        tick();
        fpu_instr_ack = 1'b0;
        fwait = 1'b1;
        #1;
        n_checks++; if (fwait_stall !== 1'b1) begin n_fail++; $display("FAIL fw_stall_exec: got %b expected 1", fwait_stall); end
        tick(); tick();
        n_checks++; if (fwait_stall !== 1'b1) begin n_fail++; $display("FAIL fw_stall_hold: got %b expected 1", fwait_stall); end
        fpu_busy = 1'b0;
        wait_done(20, seen);
        n_checks++; if (seen !== 1'b1 || fwait_stall !== 1'b0) begin
            n_fail++; $display("FAIL fw_release: got done=%b stall=%b expected 1/0", seen, fwait_stall); end
        fwait = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_load();
        int d0 = n_done;
        start_op(8'hDD, 8'h06, 1, 0, 2'd3, 0);
        fpu_instr_ack = 1'b1;
        tick();
        fpu_instr_ack = 1'b0;
        wr_word_valid = 1'b1; wr_word = 16'hABCD;
        tick(); tick();
        n_checks++; if (fpu_data_in !== 80'hABCDABCD) begin n_fail++; $display("FAIL rm_partial: got %h expected abcdabcd", fpu_data_in); end
        reset_n = 1'b0;
        #1;
        n_checks++; if ({op_ready, wr_word_ready, fpu_instr_valid, fpu_has_memory_op, done} !== 5'b0 ||
                        fpu_data_in !== 80'h0 || fpu_opcode !== 8'h0 || fpu_operand_size !== 2'd0) begin
            n_fail++; $display("FAIL rm_outputs: got flags=%b data=%h opc=%h sz=%0d expected 0", {op_ready, wr_word_ready, fpu_instr_valid, fpu_has_memory_op, done}, fpu_data_in, fpu_opcode, fpu_operand_size); end
        wr_word_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready: got %b expected 1", op_ready); end
        tick(); tick();
        n_checks++; if (n_done - d0 !== 0 || wr_word_ready !== 1'b0) begin
            n_fail++; $display("FAIL rm_abandon: got dones=%0d rdy=%b expected 0/0", n_done - d0, wr_word_ready); end
    endtask

    initial begin
        test_reset();
        test_register_op();
        test_load_single();
        test_load_80();
        test_store();
        test_timeout();
        test_fwait();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_op_sequencer.md
Name: fpu_op_sequencer

Overview:
Sequences ESC (floating-point) instructions from CPU microcode into FPU_CPU_Interface.
- Issues the instruction descriptor and holds it until the interface acks.
- For memory loads, assembles 16-bit memory words into the 80-bit operand. For stores, splits the 80-bit result back into 16-bit words.
- Tracks completion, stalls FWAIT and flags watchdog timeouts.
- Sits between the microcode/bus-unit word path and the FPU interface.

Parameters:
TIMEOUT_CYCLES, 1024, watchdog limit for cycles spent in ISSUE, EXEC_WAIT or STORE_WAIT.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
op_valid  in  1  CPU offers an instruction descriptor
op_ready  out  1  sequencer accepts a descriptor (high only in IDLE)
op_opcode  in  8  ESC opcode byte D8-DF
op_modrm  in  8  ModR/M byte
op_is_load  in  1  memory operand flows memory->FPU
op_is_store  in  1  memory operand flows FPU->memory
op_size  in  2  0=16b (1 word), 1=32b (2), 2=64b (4), 3=80b (5)
op_is_integer  in  1  integer-format operand
op_is_bcd  in  1  BCD-format operand
wr_word_valid  in  1  load word offered
wr_word  in  16  load word, least-significant word first
wr_word_ready  out  1  load word accepted
rd_word_valid  out  1  store word offered
rd_word  out  16  store word, least-significant word first
rd_word_ready  in  1  store word consumed
fwait  in  1  CPU executing FWAIT
fwait_stall  out  1  hold the CPU
done  out  1  one-cycle pulse on normal completion
timeout_err  out  1  sticky watchdog flag
fpu_instr_valid  out  1  to interface cpu_fpu_instr_valid
fpu_opcode  out  8  latched opcode
fpu_modrm  out  8  latched ModR/M
fpu_has_memory_op  out  1  load OR store
fpu_operand_size  out  2  latched op_size
fpu_is_integer  out  1  latched
fpu_is_bcd  out  1  latched
fpu_instr_ack  in  1  interface acknowledge
fpu_data_write  out  1  one-cycle operand push
fpu_data_in  out  80  assembled operand
fpu_data_read  out  1  one-cycle result pop
fpu_data_out  in  80  result from interface
fpu_data_ready  in  1  result available
fpu_busy  in  1  interface busy

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; operand, result, word counter and timer cleared. A reset mid-operation abandons the operation with no done pulse.
- op_ready = (state==IDLE). On op_valid&&op_ready, latch every descriptor field and clear word_cnt, then go to ISSUE. Accepting an op clears timeout_err.
- If op_is_load and op_is_store are both set, the op is treated as a load.
- N = words for op_size: 1, 2, 4 or 5.
- ISSUE: fpu_instr_valid=1 and descriptor outputs stable. When fpu_instr_ack is seen, fpu_instr_valid drops the next cycle. Next state: load -> LOAD_COLLECT; store -> STORE_WAIT; otherwise -> EXEC_WAIT.
- LOAD_COLLECT: wr_word_ready=1. Each accepted word is written to operand[16*word_cnt +: 16] and word_cnt increments. Unused upper bits stay 0. When the word with word_cnt==N-1 is accepted -> LOAD_PUSH.
- LOAD_PUSH: fpu_data_write=1 for exactly one cycle, with fpu_data_in=operand -> EXEC_WAIT.
- EXEC_WAIT: the first cycle is ignored. From the second cycle on, fpu_busy==0 -> IDLE, with done=1 for one cycle.
- STORE_WAIT: when fpu_data_ready=1, capture fpu_data_out, pulse fpu_data_read for one cycle, clear word_cnt -> STORE_SEND.
- STORE_SEND: rd_word_valid=1, rd_word=result[16*word_cnt +: 16]. word_cnt advances on rd_word_ready. After word N-1 is consumed -> IDLE, with done=1.
- Watchdog:
  - The timer clears on every state change.
  - In ISSUE, EXEC_WAIT or STORE_WAIT, timer==TIMEOUT_CYCLES-1 forces IDLE, sets timeout_err=1 and gives no done pulse.
  - LOAD_COLLECT and STORE_SEND are not timed; they are paced by the CPU.
- fwait_stall = fwait && (state!=IDLE). The signal is combinational, and it releases in the same cycle the state returns to IDLE.
- A new op_valid presented while the sequencer is not in IDLE is ignored because op_ready is low. The CPU holds the descriptor until it is accepted.
- wr_word_valid outside LOAD_COLLECT is ignored. rd_word_ready outside STORE_SEND is ignored.

Test Plan:
- Register op D8/C0: ack after 2 cycles, busy high for 3 cycles then low -> exactly one fpu_instr_valid burst, done pulses once, op_ready returns to 1.
- Load D8/06, size=1, words 0x0000 then 0x3F80 -> single fpu_data_write with fpu_data_in=80'h3F800000, fpu_has_memory_op=1, fpu_operand_size=1.
- Load DB/2E, size=3, words 1..5 -> fpu_data_in=80'h00050004000300020001; wr_word_valid stalled for 3 cycles mid-transfer adds no extra words.
- Store D9/16, size=3, data_ready with 80'h3FFF8000000000000000 -> fpu_data_read pulses once; rd_word sequence 0000,0000,0000,8000,3FFF; rd_word_ready withheld 2 cycles holds the word.
- Ack never arrives, TIMEOUT_CYCLES=16 -> after 16 ISSUE cycles state is IDLE, timeout_err=1, no done; the next accepted op clears timeout_err.
- fwait asserted during EXEC_WAIT -> fwait_stall=1 until done. reset_n pulled low mid-LOAD_COLLECT -> all outputs 0 immediately, op_ready=1 after release.
